// File: rtl/cache_stats_collector.sv
// cache_stats_collector
// Counts L1 data-cache and instruction-cache hit/miss events into nine
// saturating counters. A RUN/DRAIN/DONE state machine raises a level 'done'
// once the trace has ended and the controller pipelines have drained.
// 'clear' zeroes the statistics and restarts collection without a reset.

module cache_stats_collector #(
    parameter int WIDTH        = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic             op_hit,
    input  logic             clear,
    input  logic             trace_end,
    output logic [WIDTH-1:0] DC_Read_Hit,
    output logic [WIDTH-1:0] DC_Read_Miss,
    output logic [WIDTH-1:0] DC_Reads,
    output logic [WIDTH-1:0] DC_Write_Hit,
    output logic [WIDTH-1:0] DC_Write_Miss,
    output logic [WIDTH-1:0] DC_Writes,
    output logic [WIDTH-1:0] IC_Read_Hit,
    output logic [WIDTH-1:0] IC_Read_Miss,
    output logic [WIDTH-1:0] IC_Reads,
    output logic             illegal_op,
    output logic             done
);

    // Counter slots inside the counter array
    localparam int NCNT      = 9;
    localparam int IDX_DC_RH = 0;
    localparam int IDX_DC_RM = 1;
    localparam int IDX_DC_R  = 2;
    localparam int IDX_DC_WH = 3;
    localparam int IDX_DC_WM = 4;
    localparam int IDX_DC_W  = 5;
    localparam int IDX_IC_RH = 6;
    localparam int IDX_IC_RM = 7;
    localparam int IDX_IC_R  = 8;

    // Drain counter only needs to hold DRAIN_CYCLES-1
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic [WIDTH-1:0]    cnt_q [NCNT];
    logic [WIDTH-1:0]    cnt_d [NCNT];
    logic [NCNT-1:0]     cnt_max;
    logic [NCNT-1:0]     inc;
    logic                accept_ev;
    logic                illegal_q, illegal_d;

    // State register: FSM, drain counter, event counters and the illegal pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            drain_q   <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            illegal_q <= illegal_d;
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Next-state logic; clear overrides every transition and returns to RUN
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (trace_end) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                // A second trace_end here is ignored so the drain is not restarted
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (clear) begin
            state_d = ST_RUN;
            drain_d = '0;
        end
    end

    // Output logic: which counters step this cycle and whether to flag an illegal op
    always_comb begin
        accept_ev = op_valid && !clear && (state_q != ST_DONE);
        inc       = '0;
        illegal_d = 1'b0;
        if (accept_ev) begin
            case (op_code)
                2'd0: begin
                    inc[IDX_DC_R]  = 1'b1;
                    inc[IDX_DC_RH] = op_hit;
                    inc[IDX_DC_RM] = !op_hit;
                end
                2'd1: begin
                    inc[IDX_DC_W]  = 1'b1;
                    inc[IDX_DC_WH] = op_hit;
                    inc[IDX_DC_WM] = !op_hit;
                end
                2'd2: begin
                    inc[IDX_IC_R]  = 1'b1;
                    inc[IDX_IC_RH] = op_hit;
                    inc[IDX_IC_RM] = !op_hit;
                end
                default: begin
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    // Per-counter saturation detect: an all-ones counter must not wrap
    genvar gi;
    generate
        for (gi = 0; gi < NCNT; gi++) begin : gen_sat
            assign cnt_max[gi] = &cnt_q[gi];
        end
    endgenerate

    // Counter update: clear first, otherwise a saturating increment
    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear) begin
                cnt_d[i] = '0;
            end else if (inc[i] && !cnt_max[i]) begin
                cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
        end
    end

    assign DC_Read_Hit   = cnt_q[IDX_DC_RH];
    assign DC_Read_Miss  = cnt_q[IDX_DC_RM];
    assign DC_Reads      = cnt_q[IDX_DC_R];
    assign DC_Write_Hit  = cnt_q[IDX_DC_WH];
    assign DC_Write_Miss = cnt_q[IDX_DC_WM];
    assign DC_Writes     = cnt_q[IDX_DC_W];
    assign IC_Read_Hit   = cnt_q[IDX_IC_RH];
    assign IC_Read_Miss  = cnt_q[IDX_IC_RM];
    assign IC_Reads      = cnt_q[IDX_IC_R];
    assign illegal_op    = illegal_q;
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_cache_stats_collector.sv
// Testbench for cache_stats_collector.
// Stimulus pushes hand-computed expected snapshots (nine counters, illegal_op,
// done) tagged with the cycle they apply to; a monitor on the falling edge pops
// and compares them. A second, 2-bit-wide instance exercises saturation.

module tb_cache_stats_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        op_valid, op_hit, clear, trace_end;
    logic [1:0]  op_code;
    logic [31:0] dc_rh, dc_rm, dc_r, dc_wh, dc_wm, dc_w, ic_rh, ic_rm, ic_r;
    logic        illegal_op, done;

    logic        s_valid, s_hit, s_clear, s_te;
    logic [1:0]  s_code;
    logic [1:0]  s_dc_rh, s_dc_rm, s_dc_r, s_dc_wh, s_dc_wm, s_dc_w, s_ic_rh, s_ic_rm, s_ic_r;
    logic        s_illegal, s_done;

    cache_stats_collector #(.WIDTH(32), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_hit(op_hit),
        .clear(clear), .trace_end(trace_end),
        .DC_Read_Hit(dc_rh), .DC_Read_Miss(dc_rm), .DC_Reads(dc_r),
        .DC_Write_Hit(dc_wh), .DC_Write_Miss(dc_wm), .DC_Writes(dc_w),
        .IC_Read_Hit(ic_rh), .IC_Read_Miss(ic_rm), .IC_Reads(ic_r),
        .illegal_op(illegal_op), .done(done)
    );

    cache_stats_collector #(.WIDTH(2), .DRAIN_CYCLES(2)) dut_sat (
        .clk(clk), .reset(reset), .op_valid(s_valid), .op_code(s_code), .op_hit(s_hit),
        .clear(s_clear), .trace_end(s_te),
        .DC_Read_Hit(s_dc_rh), .DC_Read_Miss(s_dc_rm), .DC_Reads(s_dc_r),
        .DC_Write_Hit(s_dc_wh), .DC_Write_Miss(s_dc_wm), .DC_Writes(s_dc_w),
        .IC_Read_Hit(s_ic_rh), .IC_Read_Miss(s_ic_rm), .IC_Reads(s_ic_r),
        .illegal_op(s_illegal), .done(s_done)
    );

    typedef struct packed {
        logic [8:0][31:0] cnt;
        logic             ill;
        logic             dn;
    } snap_t;

    typedef struct {
        int    cyc;
        int    sel;
        snap_t exp;
        string name;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t mk(input int rh, input int rm, input int r,
                                 input int wh, input int wm, input int w,
                                 input int ih, input int im, input int ir,
                                 input bit ill, input bit dn);
        snap_t s;
        s.cnt[0] = 32'(rh); s.cnt[1] = 32'(rm); s.cnt[2] = 32'(r);
        s.cnt[3] = 32'(wh); s.cnt[4] = 32'(wm); s.cnt[5] = 32'(w);
        s.cnt[6] = 32'(ih); s.cnt[7] = 32'(im); s.cnt[8] = 32'(ir);
        s.ill = ill;
        s.dn  = dn;
        return s;
    endfunction

    function automatic snap_t act_main();
        snap_t s;
        s.cnt[0] = dc_rh; s.cnt[1] = dc_rm; s.cnt[2] = dc_r;
        s.cnt[3] = dc_wh; s.cnt[4] = dc_wm; s.cnt[5] = dc_w;
        s.cnt[6] = ic_rh; s.cnt[7] = ic_rm; s.cnt[8] = ic_r;
        s.ill = illegal_op;
        s.dn  = done;
        return s;
    endfunction

    function automatic snap_t act_sat();
        snap_t s;
        s.cnt[0] = 32'(s_dc_rh); s.cnt[1] = 32'(s_dc_rm); s.cnt[2] = 32'(s_dc_r);
        s.cnt[3] = 32'(s_dc_wh); s.cnt[4] = 32'(s_dc_wm); s.cnt[5] = 32'(s_dc_w);
        s.cnt[6] = 32'(s_ic_rh); s.cnt[7] = 32'(s_ic_rm); s.cnt[8] = 32'(s_ic_r);
        s.ill = s_illegal;
        s.dn  = s_done;
        return s;
    endfunction

    task automatic check_snap(input string n, input snap_t act, input snap_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("[cyc %0d] %s ok", cyc, n);
        end else begin
            $display("FAIL %s: got cnt=%h ill=%b done=%b, want cnt=%h ill=%b done=%b",
                     n, act.cnt, act.ill, act.dn, exp.cnt, exp.ill, exp.dn);
        end
    endtask

    // Scoreboard monitor: compare every expectation due at this falling edge
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.cyc < cyc) begin
                n_checks++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", mon_e.name, cyc, mon_e.cyc);
            end else if (mon_e.sel == 0) begin
                check_snap(mon_e.name, act_main(), mon_e.exp);
            end else begin
                check_snap(mon_e.name, act_sat(), mon_e.exp);
            end
        end
    end

    // Expectation for the state visible after the next rising edge
    task automatic expect_at(input int sel, input string n, input snap_t e);
        exp_t x;
        x.cyc  = cyc + 1;
        x.sel  = sel;
        x.exp  = e;
        x.name = n;
        sb_q.push_back(x);
    endtask

    task automatic drive(input bit v, input logic [1:0] c, input bit h, input bit clr, input bit te);
        @(negedge clk);
        op_valid  = v;
        op_code   = c;
        op_hit    = h;
        clear     = clr;
        trace_end = te;
    endtask

    task automatic sdrive(input bit v, input logic [1:0] c, input bit h);
        @(negedge clk);
        s_valid = v;
        s_code  = c;
        s_hit   = h;
    endtask

    snap_t zero_s, full_s;
    logic [1:0] frz_code [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    bit         frz_hit  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit         frz_te   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 1'b1;
        op_valid = 1'b0; op_code = 2'd0; op_hit = 1'b0; clear = 1'b0; trace_end = 1'b0;
        s_valid = 1'b0; s_code = 2'd0; s_hit = 1'b0; s_clear = 1'b0; s_te = 1'b0;
        zero_s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        full_s = mk(2, 1, 3, 0, 2, 2, 4, 0, 4, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        expect_at(0, "reset_main", zero_s);
        expect_at(1, "reset_sat", zero_s);

        // Saturation on the 2-bit instance
        sdrive(1, 2'd0, 1); sdrive(1, 2'd0, 1); sdrive(1, 2'd0, 1);
        expect_at(1, "sat_reach_max", mk(3, 0, 3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
        sdrive(1, 2'd0, 1);
        expect_at(1, "sat_hold_1", mk(3, 0, 3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
        sdrive(1, 2'd0, 1);
        expect_at(1, "sat_hold_2", mk(3, 0, 3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
        sdrive(1, 2'd0, 0);
        expect_at(1, "sat_miss_counts", mk(3, 1, 3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
        sdrive(1, 2'd2, 0);
        expect_at(1, "sat_others_count", mk(3, 1, 3, 0, 0, 0, 0, 1, 1, 1'b0, 1'b0));
        sdrive(1, 2'd1, 1);
        expect_at(1, "sat_write_counts", mk(3, 1, 3, 1, 0, 1, 0, 1, 1, 1'b0, 1'b0));
        sdrive(0, 2'd0, 0);

        // Basic trace: reads, writes, fetches, then trace_end
        drive(1, 2'd0, 1, 0, 0); drive(1, 2'd0, 0, 0, 0); drive(1, 2'd0, 1, 0, 0);
        expect_at(0, "reads", mk(2, 1, 3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
        drive(1, 2'd1, 0, 0, 0); drive(1, 2'd1, 0, 0, 0);
        expect_at(0, "writes", mk(2, 1, 3, 0, 2, 2, 0, 0, 0, 1'b0, 1'b0));
        repeat (4) drive(1, 2'd2, 1, 0, 0);
        expect_at(0, "fetches", full_s);
        drive(0, 2'd0, 0, 0, 1);
        expect_at(0, "te_edge", full_s);
        drive(0, 2'd0, 0, 0, 0);
        expect_at(0, "draining", full_s);
        drive(0, 2'd0, 0, 0, 0);
        full_s.dn = 1'b1;
        expect_at(0, "done_rise", full_s);

        // Events in DONE are ignored, including illegal ops and trace_end
        for (int i = 0; i < 5; i++) begin
            drive(1, frz_code[i], frz_hit[i], 0, frz_te[i]);
            expect_at(0, $sformatf("done_frozen_%0d", i), full_s);
        end

        drive(0, 2'd0, 0, 1, 0);
        expect_at(0, "clear_from_done", zero_s);
        drive(1, 2'd2, 0, 0, 0);
        expect_at(0, "fetch_miss", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1'b0, 1'b0));
        drive(1, 2'd3, 1, 0, 0);
        expect_at(0, "illegal_pulse", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1'b1, 1'b0));
        drive(0, 2'd0, 0, 0, 0);
        expect_at(0, "illegal_one_cycle", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1'b0, 1'b0));
        drive(1, 2'd0, 1, 1, 0);
        expect_at(0, "hit_with_clear", zero_s);
        drive(1, 2'd3, 0, 1, 0);
        expect_at(0, "illegal_with_clear", zero_s);

        // Event with trace_end counted; trace_end in DRAIN does not restart
        drive(1, 2'd0, 1, 0, 1);
        expect_at(0, "hit_with_te", mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
        drive(1, 2'd0, 0, 0, 1);
        expect_at(0, "drain_counts_te_ignored", mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
        drive(0, 2'd0, 0, 0, 0);
        expect_at(0, "done_after_drain", mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1));

        // clear with trace_end: stays in RUN
        drive(0, 2'd0, 0, 1, 1);
        expect_at(0, "clear_with_te", zero_s);
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'd0, 0, 0, 0);
            expect_at(0, $sformatf("stay_run_%0d", i), zero_s);
        end

        // Asynchronous reset in the middle of DRAIN
        drive(1, 2'd0, 1, 0, 0);
        expect_at(0, "pre_reset_hit", mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
        drive(0, 2'd0, 0, 0, 1);
        expect_at(0, "pre_reset_te", mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
        drive(0, 2'd0, 0, 0, 0);
        #2 reset = 1'b1;
        #1 check_snap("async_reset", act_main(), zero_s);
        drive(0, 2'd0, 0, 0, 1);
        reset = 1'b0;
        expect_at(0, "post_reset_te", zero_s);
        drive(0, 2'd0, 0, 0, 0);
        expect_at(0, "post_reset_drain", zero_s);
        drive(0, 2'd0, 0, 0, 0);
        expect_at(0, "post_reset_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1));
        drive(0, 2'd0, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
